// File: rtl/port_tx_buf.sv
`default_nettype none
// ============================================================================
//  Module   : port_tx_buf
//  Function : Transmit-side packet buffer. Incoming packets are stored in a
//             data RAM and only become visible to the reader once their
//             end-of-packet status says "keep". The descriptor FIFO holds one
//             word count per committed packet. The reader streams committed
//             packets to the MAC under out_ready flow control.
//  Revision : 1.0  initial release
// ============================================================================
module port_tx_buf #(
  parameter int DW_ADDR       = 8,
  parameter int PD_ADDR       = 4,
  parameter int MAX_PKT_WORDS = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_data_wr,
  input  logic [133:0] in_data,
  input  logic         in_valid_wr,
  input  logic         in_valid,
  input  logic         out_ready,
  output logic         out_data_wr,
  output logic [133:0] out_data,
  output logic         out_valid_wr,
  output logic         out_valid,
  output logic [31:0]  tx_pkt_cnt,
  output logic [31:0]  drop_pkt_cnt,
  output logic [31:0]  err_word_cnt
);

  // Data pointers carry one extra bit so full and empty are distinguishable.
  localparam int c_PW = DW_ADDR + 1;
  localparam int c_QW = PD_ADDR + 1;
  localparam int c_LW = $clog2(MAX_PKT_WORDS + 1);

  localparam logic [c_PW-1:0] c_DEPTH    = c_PW'(1 << DW_ADDR);
  localparam logic [c_QW-1:0] c_PD_DEPTH = c_QW'(1 << PD_ADDR);
  localparam logic [31:0]     c_MAX_W    = MAX_PKT_WORDS;
  localparam logic [c_LW-1:0] c_MAX_LEN  = c_LW'(MAX_PKT_WORDS);
  localparam logic [c_LW-1:0] c_ONE_LEN  = c_LW'(1);

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_PKT   = 2'd1,
    W_WAITV = 2'd2,
    W_DROP  = 2'd3
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LOAD = 2'd1,
    R_SEND = 2'd2
  } rstate_t;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [133:0]    r_mem  [2**DW_ADDR];
  logic [c_LW-1:0] r_dmem [2**PD_ADDR];

  // --------------------------------------------------------------------------
  // Write side
  // --------------------------------------------------------------------------
  wstate_t         r_wstate, w_wstate_nxt;
  logic [c_PW-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [c_PW-1:0] r_commit_ptr, w_commit_ptr_nxt;
  logic [c_LW-1:0] r_pkt_len, w_pkt_len_nxt;
  logic            w_mem_we;
  logic [DW_ADDR-1:0] w_mem_waddr;
  logic            w_push;
  logic [c_LW-1:0] w_push_len;
  logic            w_drop_inc;
  logic            w_err_inc;

  logic [1:0]      w_flag;
  logic            w_is_head;
  logic            w_is_tail;
  logic [c_PW-1:0] w_free;
  logic            w_head_ok;
  logic [c_PW-1:0] w_wr_inc;
  logic [c_LW-1:0] w_len_inc;

  // --------------------------------------------------------------------------
  // Descriptor FIFO
  // --------------------------------------------------------------------------
  logic [c_QW-1:0] r_dwp, r_drp;
  logic            w_dfifo_empty;
  logic            w_dfifo_full;
  logic [c_LW-1:0] w_dfifo_head;
  logic            w_pop;

  // --------------------------------------------------------------------------
  // Read side
  // --------------------------------------------------------------------------
  rstate_t         r_rstate, w_rstate_nxt;
  logic [c_PW-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [c_PW-1:0] w_rd_inc;
  logic [c_LW-1:0] r_rem, w_rem_nxt;
  logic            w_mem_re;
  logic [DW_ADDR-1:0] w_mem_raddr;
  logic [133:0]    r_rd_q;
  logic            w_tx_inc;

  logic [31:0]     r_tx_cnt, r_drop_cnt, r_err_cnt;

  assign w_flag    = in_data[133:132];
  assign w_is_head = (w_flag == 2'b01);
  assign w_is_tail = (w_flag == 2'b10);
  assign w_wr_inc  = r_wr_ptr + 1'b1;
  assign w_len_inc = r_pkt_len + 1'b1;
  assign w_rd_inc  = r_rd_ptr + 1'b1;

  // Free space is measured from the last commit point: a new head always
  // abandons whatever uncommitted words are open, so those words are free.
  // Outside an open packet wr_ptr and commit_ptr are equal.
  assign w_free    = c_DEPTH - (r_commit_ptr - r_rd_ptr);
  assign w_head_ok = (32'(w_free) >= c_MAX_W) && !w_dfifo_full;

  assign w_dfifo_empty = (r_dwp == r_drp);
  assign w_dfifo_full  = ((r_dwp - r_drp) == c_PD_DEPTH);
  assign w_dfifo_head  = r_dmem[r_drp[PD_ADDR-1:0]];

  assign out_data     = r_rd_q;
  assign tx_pkt_cnt   = r_tx_cnt;
  assign drop_pkt_cnt = r_drop_cnt;
  assign err_word_cnt = r_err_cnt;

  // Write FSM next-state: accept, store, commit or discard incoming packets.
  always_comb begin
    w_wstate_nxt     = r_wstate;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_commit_ptr_nxt = r_commit_ptr;
    w_pkt_len_nxt    = r_pkt_len;
    w_mem_we         = 1'b0;
    w_mem_waddr      = r_wr_ptr[DW_ADDR-1:0];
    w_push           = 1'b0;
    w_push_len       = r_pkt_len;
    w_drop_inc       = 1'b0;
    w_err_inc        = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (in_data_wr) begin
          if (w_is_head) begin
            if (w_head_ok) begin
              w_mem_we      = 1'b1;
              w_wr_ptr_nxt  = w_wr_inc;
              w_pkt_len_nxt = c_ONE_LEN;
              w_wstate_nxt  = W_PKT;
            end else begin
              w_wstate_nxt  = W_DROP;
            end
          end else begin
            w_err_inc = 1'b1;
          end
        end
      end
      W_PKT: begin
        if (in_data_wr && w_is_head) begin
          // Unexpected head: abandon the open packet and restart at commit_ptr.
          w_drop_inc   = 1'b1;
          w_err_inc    = 1'b1;
          w_wr_ptr_nxt = r_commit_ptr;
          if (w_head_ok) begin
            w_mem_we      = 1'b1;
            w_mem_waddr   = r_commit_ptr[DW_ADDR-1:0];
            w_wr_ptr_nxt  = r_commit_ptr + 1'b1;
            w_pkt_len_nxt = c_ONE_LEN;
          end else begin
            w_wstate_nxt  = W_DROP;
          end
        end else if (in_data_wr && (r_pkt_len == c_MAX_LEN)) begin
          // Oversized packet: rewind and swallow the remainder.
          w_wr_ptr_nxt = r_commit_ptr;
          if (in_valid_wr) begin
            w_drop_inc   = 1'b1;
            w_wstate_nxt = W_IDLE;
          end else begin
            w_wstate_nxt = W_DROP;
          end
        end else if (in_data_wr) begin
          w_mem_we      = 1'b1;
          w_wr_ptr_nxt  = w_wr_inc;
          w_pkt_len_nxt = w_len_inc;
          if (in_valid_wr) begin
            if (in_valid) begin
              w_push           = 1'b1;
              w_push_len       = w_len_inc;
              w_commit_ptr_nxt = w_wr_inc;
            end else begin
              w_wr_ptr_nxt = r_commit_ptr;
              w_drop_inc   = 1'b1;
            end
            w_wstate_nxt = W_IDLE;
          end else if (w_is_tail) begin
            w_wstate_nxt = W_WAITV;
          end
        end else if (in_valid_wr) begin
          if (in_valid) begin
            w_push           = 1'b1;
            w_commit_ptr_nxt = r_wr_ptr;
          end else begin
            w_wr_ptr_nxt = r_commit_ptr;
            w_drop_inc   = 1'b1;
          end
          w_wstate_nxt = W_IDLE;
        end
      end
      W_WAITV: begin
        if (in_data_wr) begin
          w_err_inc = 1'b1;
        end
        if (in_valid_wr) begin
          if (in_valid) begin
            w_push           = 1'b1;
            w_commit_ptr_nxt = r_wr_ptr;
          end else begin
            w_wr_ptr_nxt = r_commit_ptr;
            w_drop_inc   = 1'b1;
          end
          w_wstate_nxt = W_IDLE;
        end
      end
      W_DROP: begin
        if (in_valid_wr) begin
          w_drop_inc   = 1'b1;
          w_wstate_nxt = W_IDLE;
        end
      end
      default: begin
        w_wstate_nxt = W_IDLE;
      end
    endcase
  end

  // Write FSM state and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate     <= W_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_pkt_len    <= '0;
    end else begin
      r_wstate     <= w_wstate_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_ptr_nxt;
      r_pkt_len    <= w_pkt_len_nxt;
    end
  end

  // Data RAM write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= in_data;
    end
  end

  // Descriptor FIFO pointers; push and pop in one cycle both take effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwp <= '0;
      r_drp <= '0;
    end else begin
      if (w_push) begin
        r_dwp <= r_dwp + 1'b1;
      end
      if (w_pop) begin
        r_drp <= r_drp + 1'b1;
      end
    end
  end

  // Descriptor storage holds the word count of each committed packet.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dmem[r_dwp[PD_ADDR-1:0]] <= w_push_len;
    end
  end

  // Read FSM next-state: fetch a descriptor, prime the RAM, then stream words.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rd_ptr_nxt = r_rd_ptr;
    w_rem_nxt    = r_rem;
    w_pop        = 1'b0;
    w_mem_re     = 1'b0;
    w_mem_raddr  = r_rd_ptr[DW_ADDR-1:0];
    w_tx_inc     = 1'b0;
    out_data_wr  = 1'b0;
    out_valid_wr = 1'b0;
    out_valid    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        // Descriptors stay queued while the MAC is stalled.
        if (!w_dfifo_empty && out_ready) begin
          w_pop        = 1'b1;
          w_rem_nxt    = w_dfifo_head;
          w_rstate_nxt = R_LOAD;
        end
      end
      R_LOAD: begin
        w_mem_re     = 1'b1;
        w_rstate_nxt = R_SEND;
      end
      R_SEND: begin
        if (out_ready) begin
          out_data_wr  = 1'b1;
          w_rd_ptr_nxt = w_rd_inc;
          if (r_rem == c_ONE_LEN) begin
            out_valid_wr = 1'b1;
            out_valid    = 1'b1;
            w_tx_inc     = 1'b1;
            w_rstate_nxt = R_IDLE;
          end else begin
            // Prefetch the next word so one word leaves per cycle.
            w_mem_re    = 1'b1;
            w_mem_raddr = w_rd_inc[DW_ADDR-1:0];
            w_rem_nxt   = r_rem - 1'b1;
          end
        end
      end
      default: begin
        w_rstate_nxt = R_IDLE;
      end
    endcase
  end

  // Read FSM state and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
      r_rd_ptr <= '0;
      r_rem    <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_rem    <= w_rem_nxt;
    end
  end

  // Synchronous RAM read register; holds its word while the MAC stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_q <= '0;
    end else if (w_mem_re) begin
      r_rd_q <= r_mem[w_mem_raddr];
    end
  end

  // Statistics counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_cnt   <= '0;
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_tx_inc) begin
        r_tx_cnt <= r_tx_cnt + 32'd1;
      end
      if (w_drop_inc) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
      if (w_err_inc) begin
        r_err_cnt <= r_err_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_port_tx_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_port_tx_buf
//  Function : Self-checking bench for port_tx_buf. A packet-level model
//             predicts which packets are kept and the exact word stream the
//             MAC must see; a negedge compare process checks every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_port_tx_buf;

  localparam int MAXW   = 96;
  localparam int BUFW   = 256;
  localparam int DESC_N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_data_wr;
  logic [133:0] in_data;
  logic         in_valid_wr;
  logic         in_valid;
  logic         out_ready;
  logic         out_data_wr;
  logic [133:0] out_data;
  logic         out_valid_wr;
  logic         out_valid;
  logic [31:0]  tx_pkt_cnt;
  logic [31:0]  drop_pkt_cnt;
  logic [31:0]  err_word_cnt;

  port_tx_buf #(.DW_ADDR(8), .PD_ADDR(4), .MAX_PKT_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data_wr   (in_data_wr),
    .in_data      (in_data),
    .in_valid_wr  (in_valid_wr),
    .in_valid     (in_valid),
    .out_ready    (out_ready),
    .out_data_wr  (out_data_wr),
    .out_data     (out_data),
    .out_valid_wr (out_valid_wr),
    .out_valid    (out_valid),
    .tx_pkt_cnt   (tx_pkt_cnt),
    .drop_pkt_cnt (drop_pkt_cnt),
    .err_word_cnt (err_word_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // Model state
  logic [133:0] exp_q[$];
  bit           exp_last_q[$];
  int m_cw = 0, m_cp = 0;       // committed words / packets (stimulus side)
  int m_ow = 0, m_op = 0;       // delivered words / packets (compare side)
  int m_tx_base = 0;
  int m_drop = 0, m_err = 0;
  int pkt_id = 0;
  int pulses = 0;
  int first_cyc = 0, last_commit_cyc = 0;
  bit first_pending = 1'b0;

  logic [133:0] cmp_w;
  bit           cmp_l;

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, 134'(act), 134'(exp));
  endtask

  // Compare process: every cycle, outputs must match the expected stream.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_data_wr",  134'(out_data_wr), '0);
      check("rst_out_valid_wr", 134'({out_valid_wr, out_valid}), '0);
      check("rst_out_data",     out_data, '0);
    end else if (out_data_wr) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", 134'(out_data_wr), '0);
      end else begin
        cmp_w = exp_q.pop_front();
        cmp_l = exp_last_q.pop_front();
        check("out_data",     out_data, cmp_w);
        check("out_valid_wr", 134'(out_valid_wr), 134'(cmp_l));
        check("out_valid",    134'(out_valid), 134'(cmp_l));
        m_ow++;
        if (cmp_l) m_op++;
        if (first_pending) begin
          first_cyc     = cyc;
          first_pending = 1'b0;
        end
      end
    end else begin
      check("idle_valid_wr", 134'({out_valid_wr, out_valid}), '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_word(input logic [1:0] fl);
    in_data_wr = 1'b1;
    in_data    = {fl, 4'd0, 32'hDEAD_0000, 96'(cyc)};
    tick();
    in_data_wr = 1'b0;
    in_data    = '0;
  endtask

  // Send one packet; the model decides from buffer/descriptor occupancy
  // whether it must be kept, and queues its words if so.
  task automatic send_pkt(input int n, input bit keep);
    int used, held;
    bit acc;
    logic [133:0] w;
    logic [1:0] fl;
    logic [3:0] inv;
    used = m_cw - m_ow;
    held = m_cp - m_op;
    acc  = ((BUFW - used) >= MAXW) && (held < DESC_N) && (n <= MAXW);
    for (int i = 0; i < n; i++) begin
      if (i == 0)          fl = 2'b01;
      else if (i == n - 1) fl = 2'b10;
      else                 fl = 2'b11;
      inv = (i == n - 1) ? 4'(pkt_id % 16) : 4'd0;
      w = {fl, inv, 32'(pkt_id), 32'(i), 32'hC0DE_0000 | 32'(n), $urandom()};
      in_data_wr  = 1'b1;
      in_data     = w;
      in_valid_wr = (i == n - 1);
      in_valid    = keep;
      if (i == n - 1) last_commit_cyc = cyc;
      if (acc && keep) begin
        exp_q.push_back(w);
        exp_last_q.push_back(i == n - 1);
      end
      tick();
    end
    in_data_wr  = 1'b0;
    in_valid_wr = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    if (acc && keep) begin
      m_cw += n;
      m_cp++;
    end else begin
      m_drop++;
    end
    pkt_id++;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check32("drain_left", exp_q.size(), 0);
    idle(3);
  endtask

  logic [31:0] d0, t0;
  int p0;

  initial begin
    rst_n       = 1'b0;
    in_data_wr  = 1'b0;
    in_data     = '0;
    in_valid_wr = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    idle(3);
    check32("rst_tx",   tx_pkt_cnt,   0);
    check32("rst_drop", drop_pkt_cnt, 0);
    check32("rst_err",  err_word_cnt, 0);
    rst_n = 1'b1;
    idle(2);

    // 4-word packet, commit on tail, first word 3 cycles later.
    first_pending = 1'b1;
    send_pkt(4, 1'b1);
    wait_drain(50);
    check32("latency", first_cyc - last_commit_cyc, 3);
    check32("tx_after_4w", tx_pkt_cnt, 1);

    // 5-word packet discarded at end-of-packet.
    send_pkt(5, 1'b0);
    idle(10);
    check32("drop_after_bad", drop_pkt_cnt, 1);
    check32("tx_after_bad", tx_pkt_cnt, 1);

    // Stray middle word in idle, then a good packet.
    drive_word(2'b11);
    m_err++;
    send_pkt(3, 1'b1);
    wait_drain(50);
    check32("err_stray", err_word_cnt, 1);
    check32("tx_after_stray", tx_pkt_cnt, 2);

    // Head inside an open packet restarts it.
    drive_word(2'b01);
    drive_word(2'b11);
    m_drop++;
    m_err++;
    send_pkt(4, 1'b1);
    wait_drain(50);
    check32("drop_restart", drop_pkt_cnt, 2);
    check32("err_restart", err_word_cnt, 2);

    // Oversized packet is truncated and dropped.
    send_pkt(MAXW + 1, 1'b1);
    idle(5);
    check32("drop_oversize", drop_pkt_cnt, 3);

    // Stalled MAC: 20 packets, descriptor FIFO limits acceptance to 16.
    out_ready = 1'b0;
    d0 = drop_pkt_cnt;
    t0 = tx_pkt_cnt;
    for (int k = 0; k < 20; k++) begin
      send_pkt(10, 1'b1);
      idle(1);
    end
    check32("drop_stall", drop_pkt_cnt - d0, 4);
    check32("drop_stall_model", drop_pkt_cnt, m_drop);
    out_ready = 1'b1;
    wait_drain(3000);
    check32("tx_stall", tx_pkt_cnt - t0, 16);

    // out_ready toggling while a 6-word packet drains.
    p0 = pulses;
    send_pkt(6, 1'b1);
    for (int k = 0; k < 40; k++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
    wait_drain(50);
    check32("toggle_pulses", pulses - p0, 6);

    // Pointer wrap-around with 40 short packets.
    t0 = tx_pkt_cnt;
    for (int k = 0; k < 40; k++) begin
      send_pkt(7, 1'b1);
      idle(2);
    end
    wait_drain(1000);
    check32("tx_wrap", tx_pkt_cnt - t0, 40);

    check32("model_tx",   tx_pkt_cnt,   m_cp - m_tx_base);
    check32("model_drop", drop_pkt_cnt, m_drop);
    check32("model_err",  err_word_cnt, m_err);

    // Reset in the middle of both a readout and an open write packet.
    p0 = pulses;
    send_pkt(12, 1'b1);
    drive_word(2'b01);
    drive_word(2'b11);
    for (int k = 0; k < 50 && (pulses - p0) < 3; k++) tick();
    rst_n = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    m_cw      = m_ow;
    m_cp      = m_op;
    m_tx_base = m_cp;
    m_drop    = 0;
    m_err     = 0;
    idle(2);
    check32("midrst_tx",   tx_pkt_cnt,   0);
    check32("midrst_drop", drop_pkt_cnt, 0);
    rst_n = 1'b1;
    idle(20);
    send_pkt(4, 1'b1);
    wait_drain(50);
    check32("post_rst_tx", tx_pkt_cnt, 1);
    check32("post_rst_err", err_word_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/port_tx_buf.md
PORT_TX_BUF -- requirements
Module: port_tx_buf

Interface
REQ-001 SHALL have parameter DW_ADDR, default 8, giving a data buffer of 2^DW_ADDR 134-bit words.
REQ-002 SHALL have parameter PD_ADDR, default 4, giving a descriptor FIFO of 2^PD_ADDR packets.
REQ-003 SHALL have parameter MAX_PKT_WORDS, default 96, the largest legal packet in words.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_data_wr, input, 1 bit: strobe qualifying in_data.
REQ-007 SHALL have port in_data, input, 134 bits: [133:132] flag (01 head, 11 middle, 10 tail), [131:128] invalid byte count, [127:0] payload.
REQ-008 SHALL have port in_valid_wr, input, 1 bit: end-of-packet status strobe.
REQ-009 SHALL have port in_valid, input, 1 bit: 1 keeps the packet, 0 discards it; sampled with in_valid_wr.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream MAC can accept a word this cycle.
REQ-011 SHALL have outputs out_data_wr (1 bit), out_data (134 bits), out_valid_wr (1 bit), out_valid (1 bit), with the same encoding as the inputs.
REQ-012 SHALL have outputs tx_pkt_cnt, drop_pkt_cnt and err_word_cnt, each 32 bits, wrapping on overflow.

Function
REQ-013 SHALL run a write FSM with states W_IDLE, W_PKT, W_WAITV and W_DROP.
REQ-014 In W_IDLE, a head word SHALL be accepted and the FSM SHALL go to W_PKT when free words >= MAX_PKT_WORDS and the descriptor FIFO is not full.
REQ-015 In W_IDLE, a head word failing either check SHALL send the FSM to W_DROP, with no buffer write.
REQ-016 In W_IDLE, a non-head word SHALL be discarded and SHALL increment err_word_cnt.
REQ-017 In W_PKT, each word SHALL be written at wr_ptr and wr_ptr SHALL increment.
REQ-018 In W_PKT, a tail word SHALL send the FSM to W_WAITV, unless in_valid_wr arrives the same cycle.
REQ-019 In W_PKT, a head word SHALL be treated as a new packet: the open packet is discarded by rewind, drop_pkt_cnt increments, and err_word_cnt increments.
REQ-020 In W_PKT, a packet exceeding MAX_PKT_WORDS SHALL be truncated by moving the FSM to W_DROP with wr_ptr rewound.
REQ-021 On in_valid_wr with in_valid=1 in W_WAITV, or on the tail cycle, the block SHALL commit: push the descriptor (word count), set commit_ptr to wr_ptr, and return to W_IDLE.
REQ-022 On in_valid_wr with in_valid=0, wr_ptr SHALL rewind to commit_ptr, drop_pkt_cnt SHALL increment and the FSM SHALL return to W_IDLE.
REQ-023 W_DROP SHALL ignore words, increment drop_pkt_cnt on in_valid_wr and return to W_IDLE.
REQ-024 Data words in W_WAITV SHALL be ignored and SHALL increment err_word_cnt.
REQ-025 Pointers SHALL be DW_ADDR+1 bits; free words SHALL be 2^DW_ADDR - (wr_ptr - rd_ptr), computed modulo 2^(DW_ADDR+1) so wrap-around is correct.
REQ-026 SHALL run a read FSM with states R_IDLE, R_LOAD and R_SEND.
REQ-027 In R_IDLE, a non-empty descriptor FIFO SHALL cause a pop and a move to R_LOAD, which issues the first synchronous RAM read.
REQ-028 In R_SEND, one word SHALL be output per cycle while out_ready=1, with out_data_wr=1 and rd_ptr incremented.
REQ-029 In R_SEND, out_ready=0 SHALL hold out_data stable and drive out_data_wr=0.
REQ-030 The last word of a packet SHALL be output with out_valid_wr=1, out_valid=1 and tx_pkt_cnt+1 in that cycle, then the read FSM SHALL return to R_IDLE.
REQ-031 Latency from commit to first out_data_wr SHALL be 3 cycles with out_ready held at 1.
REQ-032 A commit and a descriptor pop in the same cycle SHALL both take effect, with FIFO count unchanged.
REQ-033 Output packets SHALL be word-for-word identical to committed input packets, in commit order.

Reset
REQ-034 While rst_n=0, SHALL clear all pointers, counters and descriptor FIFO state, set both FSMs to idle states, and drive out_data_wr, out_valid_wr and out_valid to 0 and out_data to 0.
REQ-035 Reset asserted mid-packet on either side SHALL abandon that packet, with no partial output after release.
REQ-036 RAM contents SHALL need no reset.

Verification
REQ-037 A 4-word packet (01,11,11,10) with in_valid=1 on the tail and out_ready=1 SHALL come out identical, first word 3 cycles after commit, with out_valid_wr on word 4 and tx_pkt_cnt=1.
REQ-038 A 5-word packet ending with in_valid=0 SHALL produce no output, drop_pkt_cnt=1, and leave free words at 256.
REQ-039 Sending 20 committed 10-word packets with out_ready=0 SHALL accept 16 and drop 4 with drop_pkt_cnt=4; raising out_ready SHALL emit exactly 16 packets.
REQ-040 Toggling out_ready every cycle during a 6-word packet SHALL produce exactly 6 out_data_wr pulses and unchanged data.
REQ-041 Streaming 40 committed 7-word packets to force pointer wrap SHALL deliver all 40 intact with tx_pkt_cnt=40.
REQ-042 A middle word in W_IDLE, then a normal packet, SHALL give err_word_cnt=1 and the packet delivered.
